// File: rtl/alu_normalize_pkg.sv
// alu_normalize_pkg
//   Shared ALU definitions for the normalize (CLZ/CLO) unit.
//   - state_t : FSM state encoding (IDLE, RUN, DONE)
//   - CLZ/CLO : encodings of the ctrl input
package alu_normalize_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic CLZ = 1'b0;   // count leading zeros
   localparam logic CLO = 1'b1;   // count leading ones

endpackage

// File: rtl/alu_normalize.sv
// alu_normalize
//   Sequential leading-zero / leading-one counter with normalization.
//   The operand is shifted left one bit per cycle until its MSB differs
//   from the bit being counted (or WIDTH shifts have been made).
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request pulse
//   ctrl   in   0 = CLZ, 1 = CLO (sampled with start)
//   B      in   operand (sampled with start)
//   busy   out  high while the FSM is in RUN
//   done   out  one-cycle pulse, count/norm valid
//   count  out  number of leading zeros/ones, 0..WIDTH
//   norm   out  B shifted left by count, zero-filled
//   state  out  current FSM state (debug)
//
// Handshake: start is a one-cycle request with no ready signal. It is
// accepted only when the FSM is in IDLE or DONE (busy=0); a start while
// busy=1 is dropped and B/ctrl are not resampled. Each accepted start
// produces exactly one done pulse unless rst aborts the operation.
module alu_normalize
   import alu_normalize_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] norm,
   output state_t           state
);

   logic [WIDTH-1:0] x, x_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             op, op_n;
   state_t           state_n;
   logic             stop;

   // Stop once the MSB is no longer the bit being counted, or once every
   // bit has been shifted out (all-zero CLZ / all-ones CLO operand).
   assign stop = (cnt == CW'(WIDTH)) || ((op == CLZ) ? x[WIDTH-1] : ~x[WIDTH-1]);

   always_comb begin
      state_n = state;
      x_n     = x;
      cnt_n   = cnt;
      op_n    = op;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               x_n     = B;
               op_n    = ctrl;
               cnt_n   = '0;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_n = DONE;
            end else begin
               x_n   = {x[WIDTH-2:0], 1'b0};
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x     <= '0;
         cnt   <= '0;
         op    <= CLZ;
      end else begin
         state <= state_n;
         x     <= x_n;
         cnt   <= cnt_n;
         op    <= op_n;
      end
   end

   assign busy  = (state == RUN);
   assign done  = (state == DONE);
   assign count = cnt;
   assign norm  = x;

endmodule

// File: tb/tb_alu_normalize.sv
module tb_alu_normalize;
   import alu_normalize_pkg::*;

   localparam int W  = 32;
   localparam int CW = $clog2(W) + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic          ctrl;
   logic [W-1:0]  B;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;
   logic [W-1:0]  norm;
   state_t        state;

   int errors;
   int checks;

   alu_normalize #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ctrl  (ctrl),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .count (count),
      .norm  (norm),
      .state (state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Leading bits equal to the counted value (0 for CLZ, 1 for CLO).
   function automatic int ref_count(input logic [W-1:0] b, input logic c);
      int n = 0;
      bit seen = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!seen) begin
            if (b[i] == c) n++;
            else seen = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic logic [W-1:0] ref_norm(input logic [W-1:0] b, input int n);
      logic [W-1:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[W-2:0], 1'b0};
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a negedge: presents a request, lets the next posedge accept
   // it, then scrambles B/ctrl so any resampling would be visible.
   task automatic launch(input logic [W-1:0] b, input logic c);
      start = 1'b1;
      B     = b;
      ctrl  = c;
      @(negedge clk);
      start = 1'b0;
      B     = $urandom;
      ctrl  = 1'($urandom_range(0, 1));
   endtask

   // Waits (bounded) for done; lat counts cycles from the start cycle.
   task automatic wait_done(input int lat0, output int lat, output bit timeout);
      lat     = lat0;
      timeout = 1'b0;
      while (done !== 1'b1 && lat < W + 10) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) timeout = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;          // rst must win over start
      B     = $urandom;
      ctrl  = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (state !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: state=%0d busy=%b done=%b, required state=0 busy=0 done=0",
                  state, busy, done);
      end
      checks++;
      if (count !== '0 || norm !== '0) begin
         errors++;
         $display("FAIL reset_data: count=%0d norm=%h, required 0 and 0", count, norm);
      end
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic [W-1:0] b;
      logic         c;
      int           cnt;
      logic [W-1:0] nrm;
   } vec_t;

   task automatic test_directed();
      vec_t v[6];
      int   lat;
      bit   to;
      v[0] = '{32'h8000_0000, CLZ, 0,  32'h8000_0000};
      v[1] = '{32'h0000_0001, CLZ, 31, 32'h8000_0000};
      v[2] = '{32'h0000_0000, CLZ, 32, 32'h0000_0000};
      v[3] = '{32'hFFF0_1234, CLO, 12, 32'h0123_4000};
      v[4] = '{32'hFFFF_FFFF, CLO, 32, 32'h0000_0000};
      v[5] = '{32'h7FFF_FFFF, CLO, 0,  32'h7FFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         launch(v[i].b, v[i].c);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dir%0d_busy: busy=%b, required 1", i, busy);
         end
         wait_done(1, lat, to);
         checks++;
         if (to || lat != v[i].cnt + 2) begin
            errors++;
            $display("FAIL dir%0d_latency: latency=%0d timeout=%0b, required %0d", i, lat, to, v[i].cnt + 2);
         end
         checks++;
         if (count !== CW'(v[i].cnt) || norm !== v[i].nrm) begin
            errors++;
            $display("FAIL dir%0d_result: count=%0d norm=%h, required count=%0d norm=%h",
                     i, count, norm, v[i].cnt, v[i].nrm);
         end
         repeat (3) @(negedge clk);
         checks++;
         if (done !== 1'b0 || state !== IDLE || count !== CW'(v[i].cnt) || norm !== v[i].nrm) begin
            errors++;
            $display("FAIL dir%0d_hold: done=%b state=%0d count=%0d norm=%h, required done=0 state=0 count=%0d norm=%h",
                     i, done, state, count, norm, v[i].cnt, v[i].nrm);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] b;
      logic         c;
      int           k, exp_cnt, lat;
      bit           to;
      for (int n = 0; n < 30; n++) begin
         c = 1'($urandom_range(0, 1));
         k = $urandom_range(0, W);
         b = $urandom;
         for (int i = 0; i < k; i++) b[W-1-i] = c;
         if (k < W) b[W-1-k] = ~c;
         exp_cnt = ref_count(b, c);
         launch(b, c);
         wait_done(1, lat, to);
         checks++;
         if (to || lat != exp_cnt + 2 || count !== CW'(exp_cnt) || norm !== ref_norm(b, exp_cnt)) begin
            errors++;
            $display("FAIL rand%0d: B=%h ctrl=%b latency=%0d count=%0d norm=%h, required latency=%0d count=%0d norm=%h",
                     n, b, c, lat, count, norm, exp_cnt + 2, exp_cnt, ref_norm(b, exp_cnt));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit to;
      launch(32'h0000_F000, CLZ);
      @(negedge clk);
      // Start pulse with a different operand/op while RUN must be dropped.
      start = 1'b1;
      B     = 32'hFFFF_FFFF;
      ctrl  = CLO;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, lat, to);
      checks++;
      if (to || lat != 18 || count !== CW'(16) || norm !== 32'hF000_0000) begin
         errors++;
         $display("FAIL b2b_first: latency=%0d count=%0d norm=%h, required latency=18 count=16 norm=f0000000",
                  lat, count, norm);
      end
      // New request presented in the DONE cycle.
      launch(32'h00FF_0000, CLZ);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: done=%b busy=%b, required done=0 busy=1", done, busy);
      end
      wait_done(1, lat, to);
      checks++;
      if (to || lat != 10 || count !== CW'(8) || norm !== 32'hFF00_0000) begin
         errors++;
         $display("FAIL b2b_second: latency=%0d count=%0d norm=%h, required latency=10 count=8 norm=ff000000",
                  lat, count, norm);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_abort();
      int lat, seen;
      bit to;
      launch(32'h0000_0000, CLZ);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (state !== IDLE || busy !== 1'b0 || done !== 1'b0 || count !== '0 || norm !== '0) begin
         errors++;
         $display("FAIL abort_state: state=%0d busy=%b done=%b count=%0d norm=%h, required all 0",
                  state, busy, done, count, norm);
      end
      seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done: done pulses=%0d, required 0", seen);
      end
      launch(32'h0001_0000, CLZ);
      wait_done(1, lat, to);
      checks++;
      if (to || lat != 17 || count !== CW'(15) || norm !== 32'h8000_0000) begin
         errors++;
         $display("FAIL abort_restart: latency=%0d count=%0d norm=%h, required latency=17 count=15 norm=80000000",
                  lat, count, norm);
      end
      @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      start  = 1'b0;
      ctrl   = 1'b0;
      B      = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_rst_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
